icache0_responder: RTL and testbench
====================================

# icache0_responder

Instruction-cache responder for thread-0 fetch port 0, the memory-side end of the IF stage's `proc2Icache0_addr` / `Icache0_valid` / `Icache0_data` interface. It serves two 64-bit-aligned fetch addresses per cycle from a direct-mapped, read-only line store and answers hits combinationally. On a miss it runs a single-outstanding tagged load on the processor-memory bus and fills the line. It sits between `if_stage` and the memory arbiter.

## Interface
- `NUM_LINES`, 32: number of 64-bit lines; power of two; index width `IDX_W = log2(NUM_LINES)`.
- `MEM_TAG_W`, 4: width of the memory transaction tag; tag value 0 means "no transaction".
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `proc2Icache0_addr`  in  [1:0][63:0]: fetch block addresses; bits [2:0] are ignored.
- `Icache0_valid`  out  [1:0]: port i hit this cycle.
- `Icache0_data`  out  [1:0][63:0]: line contents for port i; 64'b0 when `Icache0_valid[i]` = 0.
- `proc2mem_command`  out  2: 2'd0 = BUS_NONE, 2'd1 = BUS_LOAD; other encodings are never driven.
- `proc2mem_addr`  out  64: miss line address with [2:0] = 0; 64'b0 when the command is BUS_NONE.
- `mem2proc_response`  in  MEM_TAG_W: nonzero means the request was accepted, and the value is its tag.
- `mem2proc_data`  in  64: return data.
- `mem2proc_tag`  in  MEM_TAG_W: tag of `mem2proc_data`; 0 means no data this cycle.

## Operation
- Address split:
  - index = addr[IDX_W+2:3]
  - tag = addr[63:IDX_W+3]
- Storage: per line, one valid bit, a tag, and 64 bits of data. The store is written only by fills; there are no processor writes.
- Hit for port i: `valid[idx_i] && tag[idx_i] == tag_i` and `reset` = 0. On a hit, `Icache0_valid[i]` = 1 and `Icache0_data[i]` = the line.
- FSM states IDLE, REQ, WAIT:
  - **IDLE.** Select the miss line:
    - port 0 miss has priority;
    - otherwise a port 1 miss;
    - when both ports miss the same line, the line is selected once.
    - On a miss, latch the line address into `miss_addr` and go to REQ. With no miss, stay in IDLE.
  - **REQ.** Drive BUS_LOAD with `miss_addr`. If `mem2proc_response` != 0, latch it into `miss_tag` and go to WAIT; otherwise stay in REQ and hold the command and address unchanged.
  - **WAIT.** The command is BUS_NONE. When `mem2proc_tag == miss_tag` and `miss_tag` != 0, write `mem2proc_data` into line `miss_addr` (set valid, write tag) and go to IDLE. Data carrying any other tag is ignored.
- A redirect of the fetch address while in REQ or WAIT does not cancel the miss. The fill completes, and a new miss for the new address is selected only after returning to IDLE.
- A fill replaces the line at its index unconditionally. A line evicted this way stops hitting from the cycle after the write.
- The same line is never requested twice concurrently; there is at most one outstanding transaction.

## Timing
- Hit latency: 0 cycles. The outputs are combinational from `proc2Icache0_addr` and the array.
- Command outputs are registered from FSM state, with no combinational path from the inputs.
- Miss timeline:
  - miss seen in IDLE in cycle t;
  - BUS_LOAD driven from cycle t+1;
  - if accepted at t+1, WAIT begins at t+2;
  - a matching tag in cycle t+k writes the line at the end of t+k;
  - the address hits in cycle t+k+1.
- No write-to-read bypass. A lookup in the fill cycle sees the old line contents.
- A new miss may be selected in the first IDLE cycle after a fill, so back-to-back misses are spaced by at least 1 IDLE cycle.
- Reset:
  - all valid bits cleared, FSM to IDLE, `miss_addr` and `miss_tag` cleared;
  - during the reset cycle `Icache0_valid` = 2'b00, `Icache0_data` = 0, `proc2mem_command` = BUS_NONE, `proc2mem_addr` = 0;
  - reset in REQ or WAIT abandons the transaction, and later data carrying that tag is ignored.
- A `mem2proc_tag` match arriving in the same cycle as a non-matching response is irrelevant; only the WAIT-state tag compare matters.

## Test plan
- Cold miss, addr 0x100 on port 0, memory accepts with tag 3 one cycle later and returns data 0xDEADBEEF_CAFEF00D with tag 3 five cycles later. Required: BUS_LOAD for exactly 1 cycle at addr 0x100; valid0 = 0 until the cycle after the fill; then data0 = 0xDEADBEEF_CAFEF00D.
- Both ports at 0x208 (same line), cold. Required: one BUS_LOAD for 0x208; after the fill, `Icache0_valid` = 2'b11 with equal data on both ports.
- Port 0 hits 0x0, port 1 misses 0x8. Required: request for 0x8; valid = 2'b01 until the fill, then 2'b11.
- `mem2proc_response` = 0 for 4 cycles, then 5; interfering data with tag 2 arrives before tag 5. Required: command and address held steady for 5 cycles; tag-2 data does not fill; the tag-5 data fills.
- Conflict: fill 0x0, then fill 0x100 (same index when NUM_LINES = 32). Required: 0x0 hits before the second fill and misses in the cycle after it.
- Reset asserted in WAIT (tag 7), then tag 7 data arrives after reset is released. Required: all lines invalid, FSM in IDLE, command BUS_NONE, and no fill occurs.

Source files
------------

// File: rtl/icache0_responder_if.sv
// Bundle of the fetch-side and memory-side signals seen by icache0_responder.
//   slave  : the responder (takes fetch addresses and memory replies,
//            drives hit/data and the bus command)
//   master : the environment (if_stage fetch port plus memory arbiter)
// Ports carried:
//   proc2Icache0_addr  [NUM_LANES][64]  fetch block addresses
//   Icache0_valid      [NUM_LANES]      per-port hit
//   Icache0_data       [NUM_LANES][64]  per-port line data (0 when no hit)
//   proc2mem_command   [2]              BUS_NONE / BUS_LOAD
//   proc2mem_addr      [64]             miss line address
//   mem2proc_response  [MEM_TAG_W]      nonzero = request accepted, value is tag
//   mem2proc_data      [64]             returned line data
//   mem2proc_tag       [MEM_TAG_W]      tag of mem2proc_data, 0 = none
interface icache0_responder_if #(
  parameter int NUM_LANES = 2,
  parameter int MEM_TAG_W = 4
);
  logic [NUM_LANES-1:0][63:0] proc2Icache0_addr;
  logic [NUM_LANES-1:0]       Icache0_valid;
  logic [NUM_LANES-1:0][63:0] Icache0_data;
  logic [1:0]                 proc2mem_command;
  logic [63:0]                proc2mem_addr;
  logic [MEM_TAG_W-1:0]       mem2proc_response;
  logic [63:0]                mem2proc_data;
  logic [MEM_TAG_W-1:0]       mem2proc_tag;

  modport slave (
    input  proc2Icache0_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
    output Icache0_valid, Icache0_data, proc2mem_command, proc2mem_addr
  );

  modport master (
    output proc2Icache0_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  Icache0_valid, Icache0_data, proc2mem_command, proc2mem_addr
  );
endinterface

// File: rtl/icache0_responder.sv
// icache0_responder: thread-0 fetch port 0 instruction cache.
// Two fetch addresses per cycle are looked up combinationally in a
// direct-mapped, read-only store of NUM_LINES 64-bit lines. A miss starts a
// single outstanding tagged BUS_LOAD; the returned data fills the line.
// Ports:
//   clock  : single clock, posedge
//   reset  : synchronous, active-high
//   bus    : icache0_responder_if.slave (fetch addr/hit/data, memory bus)

// One lookup lane: splits a fetch address and compares against the line
// read at its index.
module icache0_lookup_lane #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 56
) (
  input  logic             reset,
  input  logic [63:0]      addr,
  input  logic             rd_valid,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [63:0]      rd_data,
  output logic [IDX_W-1:0] idx,
  output logic [63:3]      line,
  output logic             hit,
  output logic [63:0]      data
);
  logic [TAG_W-1:0] tag;
  // Byte offset within the 64-bit block does not take part in the lookup.
  logic             unused_offset;

  assign unused_offset = ^addr[2:0];
  assign idx  = addr[IDX_W+2:3];
  assign tag  = addr[63:IDX_W+3];
  assign line = addr[63:3];
  assign hit  = rd_valid && (rd_tag == tag) && !reset;
  assign data = hit ? rd_data : 64'b0;
endmodule

module icache0_responder #(
  parameter int NUM_LINES = 32,
  parameter int MEM_TAG_W = 4
) (
  input logic           clock,
  input logic           reset,
  icache0_responder_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = 61 - IDX_W;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e               state_q, state_d;
  // Miss line address; bits [2:0] are always zero so they are not stored.
  logic [63:3]          miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic                 fill_en;

  logic [NUM_LINES-1:0] line_valid_q;
  logic [TAG_W-1:0]     line_tag_q  [NUM_LINES];
  logic [63:0]          line_data_q [NUM_LINES];

  logic [NUM_LANES-1:0][IDX_W-1:0] lane_idx;
  logic [NUM_LANES-1:0][63:3]      lane_line;
  logic [NUM_LANES-1:0]            lane_hit;
  logic [NUM_LANES-1:0][63:0]      lane_data;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_idx = miss_addr_q[IDX_W+2:3];
  assign fill_tag = miss_addr_q[63:IDX_W+3];

  // Per-port lookup; hits are combinational from address and array.
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      icache0_lookup_lane #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
      ) u_lane (
        .reset    (reset),
        .addr     (bus.proc2Icache0_addr[i]),
        .rd_valid (line_valid_q[lane_idx[i]]),
        .rd_tag   (line_tag_q[lane_idx[i]]),
        .rd_data  (line_data_q[lane_idx[i]]),
        .idx      (lane_idx[i]),
        .line     (lane_line[i]),
        .hit      (lane_hit[i]),
        .data     (lane_data[i])
      );
    end
  endgenerate

  assign bus.Icache0_valid = lane_hit;
  assign bus.Icache0_data  = lane_data;

  // Next state. In IDLE port 0 wins; if both ports miss the same line the
  // single selection covers both. Redirects during REQ/WAIT are not looked at.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    miss_tag_d  = miss_tag_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!lane_hit[0]) begin
          miss_addr_d = lane_line[0];
          state_d     = REQ;
        end else if (!lane_hit[1]) begin
          miss_addr_d = lane_line[1];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.mem2proc_response != '0) begin
          miss_tag_d = bus.mem2proc_response;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (miss_tag_q != '0 && bus.mem2proc_tag == miss_tag_q) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command comes from the state register only; reset forces it quiet
  // in the reset cycle itself.
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = 64'b0;
    if (state_q == REQ && !reset) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = {miss_addr_q, 3'b000};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      miss_tag_q   <= '0;
      line_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      miss_tag_q  <= miss_tag_d;
      if (fill_en) line_valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: the valid bits guard them.
  always_ff @(posedge clock) begin
    if (fill_en && !reset) begin
      line_tag_q[fill_idx]  <= fill_tag;
      line_data_q[fill_idx] <= bus.mem2proc_data;
    end
  end
endmodule

// File: tb/tb_icache0_responder.sv
module tb_icache0_responder;
  localparam int NUM_LINES = 32;
  localparam int MEM_TAG_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  icache0_responder_if #(.NUM_LANES(2), .MEM_TAG_W(MEM_TAG_W)) bus ();

  icache0_responder #(.NUM_LINES(NUM_LINES), .MEM_TAG_W(MEM_TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference cache: per index, the full line address held and its data.
  bit          mv    [NUM_LINES];
  logic [60:0] mline [NUM_LINES];
  logic [63:0] mdata [NUM_LINES];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic out(input string nm, input logic [1:0] v, input logic [63:0] d0,
                     input logic [63:0] d1, input logic [1:0] cmd, input logic [63:0] ma);
    chk({nm, ".valid"}, 64'(bus.Icache0_valid), 64'(v));
    chk({nm, ".data0"}, bus.Icache0_data[0], d0);
    chk({nm, ".data1"}, bus.Icache0_data[1], d1);
    chk({nm, ".cmd"}, 64'(bus.proc2mem_command), 64'(cmd));
    chk({nm, ".maddr"}, bus.proc2mem_addr, ma);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Starts in the cycle where IDLE sees the miss. Memory stalls 'stall'
  // cycles, accepts with tag rt, optionally sends a stray tag, and returns
  // d with tag rt 'lat' cycles after acceptance. Ends at the start of the
  // cycle after the fill, inputs set, not yet checked.
  task automatic run_miss(input string nm, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] rq, input int stall, input logic [3:0] rt,
                          input int lat, input logic [3:0] noise, input logic [63:0] d,
                          input logic [1:0] vw, input logic [63:0] dw0, input logic [63:0] dw1);
    bus.proc2Icache0_addr = {a1, a0};
    bus.mem2proc_response = '0;
    bus.mem2proc_tag      = '0;
    #1;
    out({nm, ".idle"}, vw, dw0, dw1, 2'd0, 64'd0);
    for (int s = 0; s <= stall; s++) begin
      nxt();
      bus.mem2proc_response = (s == stall) ? rt : 4'd0;
      #1;
      out({nm, ".req"}, vw, dw0, dw1, 2'd1, rq);
    end
    for (int k = 1; k <= lat; k++) begin
      nxt();
      bus.mem2proc_response = '0;
      bus.mem2proc_tag      = (k == lat) ? rt : ((k == 1) ? noise : 4'd0);
      bus.mem2proc_data     = (k == lat) ? d : ~d;
      #1;
      out({nm, ".wait"}, vw, dw0, dw1, 2'd0, 64'd0);
    end
    nxt();
    bus.mem2proc_tag  = '0;
    bus.mem2proc_data = '0;
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] ln;
    ln = 64'($urandom_range(0, 3) * NUM_LINES + $urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) ln = ln + (64'd1 << 40);
    return (ln << 3) | 64'($urandom_range(0, 7));
  endfunction

  localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D3 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D4 = 64'hA5A5_0000_5A5A_FFFF;
  localparam logic [63:0] D5 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D6 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] D7 = 64'h0F0F_1E1E_2D2D_3C3C;

  initial begin
    logic [63:0] a [2];
    logic [60:0] ln [2];
    bit          h  [2];
    int          ph;
    logic [60:0] pl;
    logic [3:0]  pt;
    logic [3:0]  rsp, tg;
    logic [63:0] dat;
    logic [1:0]  ev;
    logic [63:0] ed [2];
    int          ix;

    reset = 1'b1;
    bus.proc2Icache0_addr = {64'h100, 64'h100};
    bus.mem2proc_response = '0;
    bus.mem2proc_tag      = '0;
    bus.mem2proc_data     = '0;
    nxt();
    #1;
    out("rst", 2'b00, 64'd0, 64'd0, 2'd0, 64'd0);
    nxt();
    reset = 1'b0;

    // cold miss, accepted with tag 3, data 5 cycles after acceptance
    run_miss("cold", 64'h100, 64'h100, 64'h100, 0, 4'd3, 5, 4'd0, D1, 2'b00, 64'd0, 64'd0);
    #1; out("cold.hit", 2'b11, D1, D1, 2'd0, 64'd0);

    // both ports on one line: single request
    nxt();
    run_miss("same", 64'h208, 64'h208, 64'h208, 0, 4'd4, 2, 4'd0, D2, 2'b00, 64'd0, 64'd0);
    #1; out("same.hit", 2'b11, D2, D2, 2'd0, 64'd0);
    nxt(); #1; out("same.quiet", 2'b11, D2, D2, 2'd0, 64'd0);

    // fill 0x0 (evicts 0x100 at index 0)
    nxt();
    run_miss("fill0", 64'h0, 64'h0, 64'h0, 0, 4'd1, 2, 4'd0, D3, 2'b00, 64'd0, 64'd0);
    #1; out("fill0.hit", 2'b11, D3, D3, 2'd0, 64'd0);

    // port 0 hits, port 1 misses
    nxt();
    run_miss("p1miss", 64'h0, 64'h8, 64'h8, 0, 4'd6, 3, 4'd0, D4, 2'b01, D3, 64'd0);
    #1; out("p1miss.hit", 2'b11, D3, D4, 2'd0, 64'd0);

    // stalled acceptance plus a stray tag before the real one
    nxt();
    run_miss("stall", 64'h318, 64'h318, 64'h318, 4, 4'd5, 3, 4'd2, D5, 2'b00, 64'd0, 64'd0);
    #1; out("stall.hit", 2'b11, D5, D5, 2'd0, 64'd0);

    // conflict: 0x100 replaces 0x0, which stops hitting after the fill
    nxt();
    run_miss("evict", 64'h0, 64'h100, 64'h100, 0, 4'd9, 2, 4'd0, D6, 2'b01, D3, 64'd0);
    #1; out("evict.after", 2'b10, 64'd0, D6, 2'd0, 64'd0);

    // refetch 0x0 accepted with tag 7, then reset while waiting
    nxt(); bus.mem2proc_response = 4'd7; #1;
    out("rw.req", 2'b10, 64'd0, D6, 2'd1, 64'h0);
    nxt(); bus.mem2proc_response = '0; #1;
    out("rw.wait", 2'b10, 64'd0, D6, 2'd0, 64'd0);
    nxt(); reset = 1'b1; #1;
    out("rw.rst", 2'b00, 64'd0, 64'd0, 2'd0, 64'd0);
    nxt(); reset = 1'b0; bus.mem2proc_tag = 4'd7; bus.mem2proc_data = D1; #1;
    out("rw.rel", 2'b00, 64'd0, 64'd0, 2'd0, 64'd0);
    nxt(); #1;
    out("rw.req2", 2'b00, 64'd0, 64'd0, 2'd1, 64'h0);
    nxt(); bus.mem2proc_response = 4'd8; #1;
    out("rw.acc", 2'b00, 64'd0, 64'd0, 2'd1, 64'h0);
    nxt(); bus.mem2proc_response = '0; #1;
    out("rw.stale", 2'b00, 64'd0, 64'd0, 2'd0, 64'd0);
    nxt(); bus.mem2proc_tag = 4'd8; bus.mem2proc_data = D7; #1;
    out("rw.fill", 2'b00, 64'd0, 64'd0, 2'd0, 64'd0);
    nxt(); bus.mem2proc_tag = '0; bus.mem2proc_data = '0; #1;
    out("rw.hit", 2'b01, D7, 64'd0, 2'd0, 64'd0);

    // randomized traffic against the reference cache
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) mv[i] = 1'b0;
    ph = 0; pl = '0; pt = '0;
    a[0] = rnd_addr();
    a[1] = rnd_addr();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        a[0] = rnd_addr();
        a[1] = ($urandom_range(0, 2) == 0) ? a[0] : rnd_addr();
      end
      rsp = 4'($urandom_range(0, 15));
      tg  = 4'($urandom_range(0, 15));
      dat = {$urandom, $urandom};
      if (ph == 1) rsp = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (ph == 2) begin
        case ($urandom_range(0, 3))
          0:       tg = pt;
          1:       tg = 4'((pt % 15) + 1);
          default: tg = 4'd0;
        endcase
      end
      bus.proc2Icache0_addr = {a[1], a[0]};
      bus.mem2proc_response = rsp;
      bus.mem2proc_tag      = tg;
      bus.mem2proc_data     = dat;
      #1;
      for (int p = 0; p < 2; p++) begin
        ln[p] = a[p][63:3];
        ix    = int'(ln[p] % NUM_LINES);
        h[p]  = mv[ix] && (mline[ix] == ln[p]);
        ev[p] = h[p];
        ed[p] = h[p] ? mdata[ix] : 64'd0;
      end
      out("rnd", ev, ed[0], ed[1], (ph == 1) ? 2'd1 : 2'd0,
          (ph == 1) ? {pl, 3'b000} : 64'd0);
      if (ph == 0) begin
        if (!h[0])      begin pl = ln[0]; ph = 1; end
        else if (!h[1]) begin pl = ln[1]; ph = 1; end
      end else if (ph == 1) begin
        if (rsp != 0) begin pt = rsp; ph = 2; end
      end else if (tg == pt) begin
        ix        = int'(pl % NUM_LINES);
        mv[ix]    = 1'b1;
        mline[ix] = pl;
        mdata[ix] = dat;
        ph        = 0;
      end
      nxt();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
